// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR coefficient controller.
// FIR_COEFF_SYMMETRIC_EN selects half-length symmetric coefficient packets.
package fir_ctrl_pkg;

  localparam int NUM_COEFFS  = 15;
  localparam int COEFF_WIDTH = 8;
  localparam int IDX_W       = $clog2(NUM_COEFFS);

  typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
  typedef coeff_t [NUM_COEFFS-1:0]       bank_t;
  typedef logic [IDX_W-1:0]              idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    PENDING = 2'd3
  } state_e;

  // Tap 14 down to tap 0; the default response is symmetric.
  localparam bank_t DEFAULT_COEFFS = {
    coeff_t'(-2), coeff_t'(-3), coeff_t'(-4), coeff_t'(0),  coeff_t'(9),
    coeff_t'(21), coeff_t'(32), coeff_t'(36), coeff_t'(32), coeff_t'(21),
    coeff_t'(9),  coeff_t'(0),  coeff_t'(-4), coeff_t'(-3), coeff_t'(-2)
  };

`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int PKT_LEN = (NUM_COEFFS + 1) / 2;
`else
  localparam int PKT_LEN = NUM_COEFFS;
`endif

  localparam idx_t LAST_IDX = idx_t'(PKT_LEN - 1);
  localparam idx_t TOP_IDX  = idx_t'(NUM_COEFFS - 1);

  // Second write target for a beat; equals the primary index when not symmetric.
  function automatic idx_t mirror_idx(input idx_t idx);
`ifdef FIR_COEFF_SYMMETRIC_EN
    return TOP_IDX - idx;
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register pair; shadow is written beat by beat and
// copied wholesale into active on commit. Mirror writes serve FIR_COEFF_SYMMETRIC_EN.
module fir_coeff_bank
  import fir_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  idx_t                              wr_idx,
  input  idx_t                              wr_mirror_idx,
  input  coeff_t                            wr_data,
  input  logic                              commit,
  output logic [NUM_COEFFS*COEFF_WIDTH-1:0] active_flat
);

  bank_t shadow_q, shadow_d;
  bank_t active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[wr_idx]        = wr_data;
      shadow_d[wr_mirror_idx] = wr_data;
    end
  end

  always_comb begin
    active_d = active_q;
    if (commit) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= DEFAULT_COEFFS;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_flat = active_q;

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Run-time coefficient controller: loads packets into a shadow bank and commits
// them on a FIR frame boundary. FIR_COEFF_SYMMETRIC_EN enables half-length packets.
module fir_coeff_ctrl #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int NUM_COEFFS             = 15,
  parameter int COEFF_WIDTH            = 8
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready,
  input  logic                              frm_tvalid,
  input  logic                              frm_tready,
  input  logic                              frm_tlast,
  output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs_flat,
  output logic                              swap_pulse,
  output logic                              pending,
  output logic                              load_err
);

  import fir_ctrl_pkg::*;

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  logic   load_err_q, load_err_d;
  logic   swap_pulse_q, swap_pulse_d;

  logic   cfg_beat;
  logic   frm_boundary;
  logic   wr_en;
  idx_t   wr_idx;
  logic   commit;
  logic   unused_tdata_hi;

  assign cfg_beat        = s00_axis_tvalid & s00_axis_tready;
  assign frm_boundary    = frm_tvalid & frm_tready & frm_tlast;
  assign unused_tdata_hi = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:COEFF_WIDTH];

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      load_err_q   <= 1'b0;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      load_err_q   <= load_err_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    load_err_d   = load_err_q;
    swap_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_beat) begin
          if (s00_axis_tlast) begin
            load_err_d = 1'b1;
          end else begin
            idx_d   = idx_t'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cfg_beat) begin
          if (idx_q == LAST_IDX) begin
            if (s00_axis_tlast) begin
              state_d = PENDING;
            end else begin
              load_err_d = 1'b1;
              state_d    = DRAIN;
            end
          end else if (s00_axis_tlast) begin
            load_err_d = 1'b1;
            state_d    = IDLE;
          end else begin
            idx_d = idx_q + idx_t'(1);
          end
        end
      end
      DRAIN: begin
        if (cfg_beat && s00_axis_tlast) begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        // A boundary that coincides with the final beat is seen in LOAD, so it never commits.
        if (frm_boundary) begin
          swap_pulse_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s00_axis_tready = s00_axis_aresetn && (state_q != PENDING);
    pending         = (state_q == PENDING);
    wr_en           = cfg_beat && ((state_q == IDLE) || (state_q == LOAD));
    wr_idx          = (state_q == IDLE) ? '0 : idx_q;
    commit          = (state_q == PENDING) && frm_boundary;
  end

  fir_coeff_bank u_bank (
    .clk           (s00_axis_aclk),
    .rst_n         (s00_axis_aresetn),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_mirror_idx (mirror_idx(wr_idx)),
    .wr_data       (coeff_t'(s00_axis_tdata[COEFF_WIDTH-1:0])),
    .commit        (commit),
    .active_flat   (coeffs_flat)
  );

  assign swap_pulse = swap_pulse_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl; honours FIR_COEFF_SYMMETRIC_EN for packet length.
module tb_fir_coeff_ctrl;

  localparam int NC = 15;
  localparam int CW = 8;
  localparam int DW = 32;
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int PKT = 8;
  localparam bit SYM = 1'b1;
`else
  localparam int PKT = 15;
  localparam bit SYM = 1'b0;
`endif

  localparam logic [NC*CW-1:0] DEF = {8'hFE, 8'hFD, 8'hFC, 8'h00, 8'h09, 8'h15, 8'h20, 8'h24,
                                      8'h20, 8'h15, 8'h09, 8'h00, 8'hFC, 8'hFD, 8'hFE};

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic          f_tvalid;
  logic          f_tready;
  logic          f_tlast;
  logic [NC*CW-1:0] coeffs;
  logic          swap;
  logic          pend;
  logic          lerr;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_coeff_ctrl dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (aresetn),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (s_tready),
    .frm_tvalid       (f_tvalid),
    .frm_tready       (f_tready),
    .frm_tlast        (f_tlast),
    .coeffs_flat      (coeffs),
    .swap_pulse       (swap),
    .pending          (pend),
    .load_err         (lerr)
  );

  // Beat k of a packet carries base+k; symmetric packets mirror onto taps 14-k.
  function automatic logic [NC*CW-1:0] pkt_flat(input logic [7:0] base);
    logic [NC*CW-1:0] r;
    int k;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      k = (SYM && i >= PKT) ? (NC - 1 - i) : i;
      r[i*CW +: CW] = base + 8'(k);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] v, input logic last, input logic with_frm);
    s_tdata  = {24'hA5C35A, v};
    s_tvalid = 1'b1;
    s_tlast  = last;
    if (with_frm) begin
      f_tvalid = 1'b1;
      f_tready = 1'b1;
      f_tlast  = 1'b1;
    end
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    f_tvalid = 1'b0;
    f_tready = 1'b0;
    f_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base, input int n, input logic frm_on_last);
    for (int k = 0; k < n; k++) begin
      send_beat(base + 8'(k), (k == n - 1), frm_on_last && (k == n - 1));
    end
  endtask

  task automatic boundary();
    f_tvalid = 1'b1;
    f_tready = 1'b1;
    f_tlast  = 1'b1;
    tick();
    f_tvalid = 1'b0;
    f_tready = 1'b0;
    f_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_run++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_in_tready: got %b want 0", s_tready); end
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_in_pending: got %b want 0", pend); end
    n_run++; if (lerr !== 1'b0) begin n_fail++; $display("FAIL reset_in_load_err: got %b want 0", lerr); end
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL reset_in_swap: got %b want 0", swap); end
    aresetn = 1'b1;
    tick();
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL reset_coeffs: got %h want %h", coeffs, DEF); end
    n_run++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b want 1", s_tready); end
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", pend); end
  endtask

  task automatic test_good_load();
    send_pkt(8'd1, PKT, 1'b0);
    n_run++; if (pend !== 1'b1) begin n_fail++; $display("FAIL good_pending: got %b want 1", pend); end
    n_run++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL good_tready_pend: got %b want 0", s_tready); end
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL good_coeffs_early: got %h want %h", coeffs, DEF); end
    tick();
    tick();
    n_run++; if (pend !== 1'b1) begin n_fail++; $display("FAIL good_pending_hold: got %b want 1", pend); end
    f_tvalid = 1'b1;
    f_tready = 1'b1;
    f_tlast  = 1'b0;
    tick();
    tick();
    tick();
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL good_coeffs_midframe: got %h want %h", coeffs, DEF); end
    f_tlast = 1'b1;
    tick();
    f_tvalid = 1'b0;
    f_tready = 1'b0;
    f_tlast  = 1'b0;
    n_run++; if (coeffs !== pkt_flat(8'd1)) begin n_fail++; $display("FAIL good_coeffs_new: got %h want %h", coeffs, pkt_flat(8'd1)); end
    n_run++; if (swap !== 1'b1) begin n_fail++; $display("FAIL good_swap_on: got %b want 1", swap); end
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL good_pending_clr: got %b want 0", pend); end
    n_run++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL good_tready_back: got %b want 1", s_tready); end
    tick();
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL good_swap_off: got %b want 0", swap); end
    n_run++; if (lerr !== 1'b0) begin n_fail++; $display("FAIL good_load_err: got %b want 0", lerr); end
  endtask

  task automatic test_short_packet();
    int short_n;
    short_n = SYM ? 5 : 10;
    send_pkt(8'h40, short_n, 1'b0);
    n_run++; if (lerr !== 1'b1) begin n_fail++; $display("FAIL short_load_err: got %b want 1", lerr); end
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL short_pending: got %b want 0", pend); end
    n_run++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL short_tready: got %b want 1", s_tready); end
    boundary();
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL short_swap: got %b want 0", swap); end
    n_run++; if (coeffs !== pkt_flat(8'd1)) begin n_fail++; $display("FAIL short_coeffs: got %h want %h", coeffs, pkt_flat(8'd1)); end
    send_pkt(8'hC8, PKT, 1'b0);
    n_run++; if (pend !== 1'b1) begin n_fail++; $display("FAIL short_next_pending: got %b want 1", pend); end
    boundary();
    n_run++; if (coeffs !== pkt_flat(8'hC8)) begin n_fail++; $display("FAIL short_next_coeffs: got %h want %h", coeffs, pkt_flat(8'hC8)); end
    n_run++; if (swap !== 1'b1) begin n_fail++; $display("FAIL short_next_swap: got %b want 1", swap); end
    n_run++; if (lerr !== 1'b1) begin n_fail++; $display("FAIL short_err_sticky: got %b want 1", lerr); end
  endtask

  task automatic test_long_packet();
    do_reset();
    n_run++; if (lerr !== 1'b0) begin n_fail++; $display("FAIL long_err_cleared: got %b want 0", lerr); end
    for (int k = 0; k < PKT + 3; k++) begin
      if (k >= PKT) begin
        n_run++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL long_drain_tready beat %0d: got %b want 1", k + 1, s_tready); end
      end
      send_beat(8'h60 + 8'(k), (k == PKT + 2), 1'b0);
    end
    n_run++; if (lerr !== 1'b1) begin n_fail++; $display("FAIL long_load_err: got %b want 1", lerr); end
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL long_pending: got %b want 0", pend); end
    boundary();
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL long_swap: got %b want 0", swap); end
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL long_coeffs: got %h want %h", coeffs, DEF); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_pkt(8'h10, PKT, 1'b1);
    n_run++; if (pend !== 1'b1) begin n_fail++; $display("FAIL simul_pending: got %b want 1", pend); end
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL simul_swap: got %b want 0", swap); end
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL simul_coeffs: got %h want %h", coeffs, DEF); end
    f_tvalid = 1'b1;
    f_tready = 1'b0;
    f_tlast  = 1'b1;
    tick();
    tick();
    tick();
    f_tvalid = 1'b0;
    f_tlast  = 1'b0;
    n_run++; if (pend !== 1'b1) begin n_fail++; $display("FAIL stall_pending: got %b want 1", pend); end
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL stall_swap: got %b want 0", swap); end
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL stall_coeffs: got %h want %h", coeffs, DEF); end
    boundary();
    n_run++; if (coeffs !== pkt_flat(8'h10)) begin n_fail++; $display("FAIL simul_next_coeffs: got %h want %h", coeffs, pkt_flat(8'h10)); end
    n_run++; if (swap !== 1'b1) begin n_fail++; $display("FAIL simul_next_swap: got %b want 1", swap); end
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL simul_next_pending: got %b want 0", pend); end
  endtask

  task automatic test_async_reset();
    send_pkt(8'h20, PKT, 1'b0);
    n_run++; if (pend !== 1'b1) begin n_fail++; $display("FAIL areset_pre_pending: got %b want 1", pend); end
    #2;
    aresetn = 1'b0;
    #1;
    n_run++; if (pend !== 1'b0) begin n_fail++; $display("FAIL areset_pending: got %b want 0", pend); end
    n_run++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL areset_tready: got %b want 0", s_tready); end
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL areset_coeffs: got %h want %h", coeffs, DEF); end
    tick();
    aresetn = 1'b1;
    tick();
    boundary();
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL areset_swap: got %b want 0", swap); end
    n_run++; if (coeffs !== DEF) begin n_fail++; $display("FAIL areset_coeffs_after: got %h want %h", coeffs, DEF); end
    n_run++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL areset_tready_after: got %b want 1", s_tready); end
    tick();
    n_run++; if (swap !== 1'b0) begin n_fail++; $display("FAIL areset_swap_late: got %b want 0", swap); end
  endtask

  initial begin
    aresetn  = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    f_tvalid = 1'b0;
    f_tready = 1'b0;
    f_tlast  = 1'b0;
    test_reset();
    test_good_load();
    test_short_packet();
    test_long_packet();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
- Run-time coefficient controller for the 15-tap transposed FIR.
- Accepts coefficient packets on an AXI-Stream config port into a shadow bank.
- Commits the shadow bank to the active bank only on a frame boundary of the FIR input stream, so no output frame is filtered with a mix of old and new taps.
- Drives the FIR's flattened coefficient bus and reports status.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, config stream data width; coefficient taken from bits [COEFF_WIDTH-1:0].
- NUM_COEFFS, 15, number of FIR taps.
- COEFF_WIDTH, 8, signed coefficient width.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_aresetn  in  1  reset, asynchronous, active-low.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  coefficient beat.
- s00_axis_tvalid  in  1  config beat valid.
- s00_axis_tlast  in  1  last coefficient of packet.
- s00_axis_tready  out  1  config beat accepted.
- frm_tvalid  in  1  FIR input stream tvalid (monitor only).
- frm_tready  in  1  FIR input stream tready (monitor only).
- frm_tlast  in  1  FIR input stream tlast (monitor only).
- coeffs_flat  out  NUM_COEFFS*COEFF_WIDTH  active taps; tap i at [i*COEFF_WIDTH +: COEFF_WIDTH].
- swap_pulse  out  1  one-cycle strobe after a commit.
- pending  out  1  shadow bank complete, awaiting frame boundary.
- load_err  out  1  sticky malformed-packet flag.

Behaviour:
- Reset (async assert, synchronous deassert by user):
  - Active bank = -2,-3,-4,0,9,21,32,36,32,21,9,0,-4,-3,-2 (tap 0..14).
  - Shadow bank cleared; state IDLE.
  - s00_axis_tready=0, swap_pulse=0, pending=0, load_err=0.
  - Reset mid-load or mid-pending discards the shadow bank; the active bank returns to defaults.
- Beat acceptance: a beat is accepted on any edge with tvalid&tready. Frame boundary = frm_tvalid&frm_tready&frm_tlast.
- IDLE:
  - tready=1.
  - An accepted beat writes shadow[0], sets idx=1, and moves to LOAD.
  - tlast on this first beat: short error, stay IDLE.
- LOAD:
  - tready=1; each accepted beat writes shadow[idx], then idx++.
  - tlast with idx==NUM_COEFFS-1: go to PENDING.
  - tlast with idx<NUM_COEFFS-1: short packet, set load_err, discard, go to IDLE.
  - Beat idx==NUM_COEFFS-1 without tlast: long packet, set load_err, go to DRAIN.
- DRAIN:
  - tready=1; discard beats until tlast is accepted, then go to IDLE.
- PENDING:
  - tready=0, pending=1.
  - A frame boundary loads active<=shadow on the same edge; the next frame's first sample sees the new taps.
  - Then go to IDLE with swap_pulse=1 for exactly the following cycle.
  - A boundary in the same cycle as the final LOAD beat does not commit; the next boundary does.
- Load sequencing: a new packet cannot start until the pending commit completes (back-pressure via tready).
- load_err: sticky; cleared only by reset.
- Stored coefficient value: tdata[COEFF_WIDTH-1:0] stored as is; upper bits ignored.
- Latency: last config beat to pending=1 is 1 cycle. Boundary to new coeffs_flat is 1 edge.

Optional Feature:
- Macro: FIR_COEFF_SYMMETRIC_EN.
- Defined:
  - Packet length is (NUM_COEFFS+1)/2 = 8 beats.
  - Beat k writes shadow[k] and shadow[NUM_COEFFS-1-k].
  - Length checks use 8.
- Undefined: full NUM_COEFFS-beat packets as above.

Decomposition:
- Package fir_ctrl_pkg:
  - NUM_COEFFS and COEFF_WIDTH localparams.
  - coeff_t (signed [COEFF_WIDTH-1:0]).
  - DEFAULT_COEFFS array.
  - State enum {IDLE, LOAD, DRAIN, PENDING}.
  - PKT_LEN constant, macro-dependent.
- One sub-module, fir_coeff_bank: shadow/active register pair.
  - Inputs: write-enable/index/data (and mirror index) and commit.
  - Output: flattened active bus.
  - The FSM and counter stay in fir_coeff_ctrl.

Test Plan:
- Reset: release reset -> coeffs_flat equals default taps; tready=1; pending=0; load_err=0.
- Good load: send 15 beats 1..15 with tlast on beat 15, then a FIR frame of 4 samples, tlast on the 4th -> pending=1 from the cycle after beat 15 until the boundary. Taps 1..15 appear the edge after the boundary. swap_pulse lasts 1 cycle. tready=0 while pending.
- Short packet: 10 beats with tlast on the 10th -> load_err=1, active bank unchanged, state IDLE. A following good packet commits normally; load_err stays 1.
- Long packet: 18 beats with tlast on the 18th -> load_err=1, beats 16-18 consumed with tready=1, no commit.
- Simultaneous events:
  - Frame boundary on the same edge as final config beat -> no commit.
  - Next boundary commits.
  - frm_tvalid=1, frm_tready=0, frm_tlast=1 never commits.
- Async reset mid-PENDING: assert aresetn=0 asynchronously -> outputs reset immediately; defaults restored; later boundary causes no swap_pulse. With FIR_COEFF_SYMMETRIC_EN, 8 beats 1..8 -> taps 1..8,7..1.
